// File: rtl/seq_signed_divider.sv
// Multicycle signed divider (restoring shift-subtract, one quotient bit per clock).
// Produces quotient on div_lo and remainder on div_hi with truncate-toward-zero rounding.
module seq_signed_divider #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             divOp,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] div_hi,
    output logic [WIDTH-1:0] div_lo,
    output logic             divby0flag,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   abs_b_q, abs_b_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   div_hi_q, div_hi_d;
    logic [WIDTH-1:0]   div_lo_q, div_lo_d;
    logic               flag_q, flag_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   rem_sh;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            abs_b_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            div_hi_q <= '0;
            div_lo_q <= '0;
            flag_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            abs_b_q  <= abs_b_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            div_hi_q <= div_hi_d;
            div_lo_q <= div_lo_d;
            flag_q   <= flag_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and datapath; |divisor| <= 2**(WIDTH-1) so the shifted remainder never overflows
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        abs_b_d  = abs_b_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        div_hi_d = div_hi_q;
        div_lo_d = div_lo_q;
        flag_d   = flag_q;
        done_d   = 1'b0;
        rem_sh   = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};

        case (state_q)
            S_IDLE: begin
                if (divOp) begin
                    if (divisor == '0) begin
                        flag_d = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        sign_a_d = dividend[WIDTH-1];
                        sign_b_d = divisor[WIDTH-1];
                        quo_d    = dividend[WIDTH-1] ? WIDTH'(WIDTH'(0) - dividend) : dividend;
                        abs_b_d  = divisor[WIDTH-1] ? WIDTH'(WIDTH'(0) - divisor) : divisor;
                        rem_d    = '0;
                        cnt_d    = '0;
                        flag_d   = 1'b0;
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
                rem_d = rem_sh;
                if (rem_sh >= abs_b_q) begin
                    rem_d    = WIDTH'(rem_sh - abs_b_q);
                    quo_d[0] = 1'b1;
                end
                cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                div_lo_d = (sign_a_q ^ sign_b_q) ? WIDTH'(WIDTH'(0) - quo_q) : quo_q;
                div_hi_d = sign_a_q ? WIDTH'(WIDTH'(0) - rem_q) : rem_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign div_hi     = div_hi_q;
    assign div_lo     = div_lo_q;
    assign divby0flag = flag_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
